// File: rtl/memoria_de_instrucoes_carregavel.sv
// Instruction memory loaded at run time over a valid/ready stream, then read by PC
// with one cycle of registered latency. Supports reload without reset.
module memoria_de_instrucoes_carregavel #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26,
    parameter int MEM_SIZE   = 256,
    parameter int CNT_WIDTH  = $clog2(MEM_SIZE + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instrucao,
    input  logic                  carga_valida,
    input  logic [DATA_WIDTH-1:0] carga_dado,
    input  logic                  carga_fim,
    output logic                  carga_pronta,
    input  logic                  recarregar,
    output logic                  em_execucao,
    output logic [CNT_WIDTH-1:0]  palavras,
    output logic                  fora_de_faixa
);

    // Load stream handshake: a word moves when carga_valida and carga_pronta are both
    // high at a posedge; the sender keeps carga_dado/carga_fim stable until then.

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CMP_W = (ADDR_WIDTH > CNT_WIDTH) ? ADDR_WIDTH : CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] ULTIMO = CNT_WIDTH'(MEM_SIZE - 1);

    typedef enum logic {
        CARGA    = 1'b0,
        EXECUCAO = 1'b1
    } estado_t;

    estado_t estado;
    estado_t prox_estado;

    // The write pointer always equals the loaded word count, so one register serves both.
    logic [CNT_WIDTH-1:0]  ptr;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic transferencia;
    logic ultima_palavra;
    logic pc_valido;

    always_comb begin
        carga_pronta   = (estado == CARGA);
        em_execucao    = (estado == EXECUCAO);
        transferencia  = carga_valida & carga_pronta;
        ultima_palavra = carga_fim | (ptr == ULTIMO);
        pc_valido      = (CMP_W'(pc) < CMP_W'(ptr));
        prox_estado    = estado;
        case (estado)
            CARGA: begin
                if (transferencia && ultima_palavra) prox_estado = EXECUCAO;
            end
            EXECUCAO: begin
                if (recarregar) prox_estado = CARGA;
            end
            default: prox_estado = CARGA;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= CARGA;
            ptr           <= '0;
            instrucao     <= '0;
            fora_de_faixa <= 1'b0;
        end else begin
            estado <= prox_estado;
            case (estado)
                CARGA: begin
                    // Fetch sees NOPs until the edge after the final word is accepted.
                    instrucao     <= '0;
                    fora_de_faixa <= 1'b0;
                    if (transferencia) ptr <= ptr + CNT_WIDTH'(1);
                end
                EXECUCAO: begin
                    if (recarregar) begin
                        ptr           <= '0;
                        instrucao     <= '0;
                        fora_de_faixa <= 1'b0;
                    end else if (pc_valido) begin
                        instrucao     <= mem[pc[IDX_W-1:0]];
                        fora_de_faixa <= 1'b0;
                    end else begin
                        instrucao     <= '0;
                        fora_de_faixa <= 1'b1;
                    end
                end
                default: begin
                    instrucao     <= '0;
                    fora_de_faixa <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset so a reset does not clear the array.
    always_ff @(posedge clock) begin
        if (transferencia) mem[ptr[IDX_W-1:0]] <= carga_dado;
    end

    assign palavras = ptr;

endmodule
